pwr_seq_ctrl: RTL and testbench
===============================

// Module: pwr_seq_ctrl
// PURPOSE
//  Device power/reset sequencer downstream of the power-on timer (pwrdwn/reset_init generator).
//  Consumes its pwrdwn and reset_init levels.
//  Releases external converter/PLL power-down, then device reset, then waits for PLL lock.
//  Only after lock does it release system reset to the fabric. Retries failed lock by power-cycling; latches fault after MAX_RETRY.
// PARAMETERS
//  CW        32       counter width; must hold max(T_PWR,T_RST,T_LOCK)
//  T_PWR     100000   cycles pwr_en high before RST_HOLD may start
//  T_RST     10000    min cycles dev_rst_n held low (RST_HOLD, RETRY)
//  T_LOCK    1000000  lock timeout in WAIT_LOCK, cycles
//  LOCK_FILT 16       consecutive synced-lock cycles required to declare lock
//  MAX_RETRY 3        power-cycle retries before FAULT
//  RW        4        retry_cnt width
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   synchronous, active-low reset
//  pwrdwn_in  in   1   from power-on timer; 1 = keep devices powered down (clk domain)
//  reset_in   in   1   from power-on timer; 1 = hold devices in reset (clk domain)
//  lock       in   1   external PLL lock, asynchronous; 2-FF synchronised internally -> lock_s
//  pwr_en     out  1   1 = release device power-down
//  dev_rst_n  out  1   device reset, active-low
//  sys_rst    out  1   fabric reset, active-high
//  ready      out  1   1 = sequence complete, lock held
//  fault      out  1   1 = retries exhausted (sticky)
//  retry_cnt  out  RW  retries performed since reset/OFF
// BEHAVIOUR
//  Outputs are Moore-decoded from the registered state; no combinational input->output path.
//  Reset (reset_n=0 at edge): state=OFF, cnt=0, filt=0, retry_cnt=0, sync FFs=0.
//  Reset outputs: pwr_en=0, dev_rst_n=0, sys_rst=1, ready=0, fault=0.
//  State output table (pwr_en/dev_rst_n/sys_rst/ready/fault):
//   OFF 0/0/1/0/0; PWR_UP 1/0/1/0/0; RST_HOLD 1/0/1/0/0; WAIT_LOCK 1/1/1/0/0.
//   RUN 1/1/0/1/0; RETRY 0/0/1/0/0; FAULT 0/0/1/0/1.
//  cnt clears on every state change and otherwise counts up, saturating at all-ones.
//  Transition priority: reset_n > pwrdwn_in > reset_in > state-local.
//  - pwrdwn_in=1 in any state except FAULT -> OFF next edge; retry_cnt cleared.
//  - reset_in=1 in WAIT_LOCK or RUN -> RST_HOLD; retry_cnt kept.
//  State-local transitions:
//  - OFF: pwrdwn_in=0 -> PWR_UP.
//  - PWR_UP: cnt==T_PWR-1 -> RST_HOLD.
//  - RST_HOLD: cnt>=T_RST-1 and reset_in=0 -> WAIT_LOCK.
//    If reset_in stays 1, hold indefinitely; cnt saturates.
//  - WAIT_LOCK: filt counts consecutive lock_s=1 cycles; lock_s=0 clears it.
//    filt==LOCK_FILT-1 with lock_s=1 -> RUN.
//    Else cnt==T_LOCK-1: retry_cnt<MAX_RETRY -> RETRY; else -> FAULT.
//    If lock completes on the timeout cycle, RUN wins.
//  - RUN: lock_s=0 for a single cycle -> WAIT_LOCK.
//    sys_rst reasserts next cycle; no retry increment.
//  - RETRY: retry_cnt += 1 on entry; cnt==T_RST-1 -> PWR_UP.
//  - FAULT: terminal; exit only via reset_n. pwrdwn_in and reset_in are ignored.
//  Latency:
//   pwrdwn_in 1->0 sampled at edge k -> pwr_en=1 after edge k.
//   lock rise -> ready after 2 sync edges + LOCK_FILT edges.
//  Minimum sequence from pwrdwn_in fall to ready: T_PWR+T_RST+2+LOCK_FILT cycles.
//  retry_cnt never wraps; max value MAX_RETRY.
// TESTING (T_PWR=8, T_RST=4, T_LOCK=20, LOCK_FILT=4, MAX_RETRY=2)
//  1 Nominal: release reset_n; pwrdwn_in 1->0 at cycle 10; reset_in=0; lock=1 throughout.
//    pwr_en=1 at 11; dev_rst_n=1 at 23; ready=1, sys_rst=0 at 29.
//  2 Lock never rises:
//    RETRY entered at 43 with retry_cnt=1; second retry gives retry_cnt=2.
//    Third timeout -> FAULT: fault=1, pwr_en=0, sys_rst=1; pwrdwn_in toggles ignored.
//  3 In RUN, drop lock for 1 cycle: ready=0, sys_rst=1 within 3 edges; state WAIT_LOCK.
//    lock back for 6 cycles -> ready=1; retry_cnt unchanged (0).
//  4 reset_in=1 during RST_HOLD for 50 cycles:
//    dev_rst_n stays 0 until reset_in falls, then rises next edge.
//    reset_in=1 in RUN -> dev_rst_n=0, ready=0 next edge.
//  5 pwrdwn_in=1 mid-WAIT_LOCK after 1 retry:
//    OFF next edge; all outputs at reset values; retry_cnt=0.
//  6 reset_n=0 asserted in RUN and in FAULT: next edge all outputs at reset values.
//    lock glitch shorter than LOCK_FILT never reaches RUN.

Source files
------------

// File: rtl/pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pwr_seq_ctrl
//
// Device power/reset sequencer that sits after the power-on timer. The
// external converter/PLL power-down is released first, then the device reset,
// and then the sequencer waits for a filtered PLL lock. Only once lock is held
// is the fabric system reset released. If lock does not arrive in time, the
// devices are power-cycled. After MAX_RETRY failed attempts the sequencer
// latches a fault, and only reset_n clears it.
//
// Ports
//   clk        in   1   system clock
//   reset_n    in   1   synchronous, active-low reset
//   pwrdwn_in  in   1   1 = keep devices powered down (from power-on timer)
//   reset_in   in   1   1 = hold devices in reset (from power-on timer)
//   lock       in   1   PLL lock, asynchronous (two-flop synchronised here)
//   pwr_en     out  1   1 = release device power-down
//   dev_rst_n  out  1   device reset, active-low
//   sys_rst    out  1   fabric reset, active-high
//   ready      out  1   1 = sequence complete and lock held
//   fault      out  1   1 = retries exhausted (sticky until reset_n)
//   retry_cnt  out  RW  power-cycle retries since reset / power-down
//
// All outputs are decoded from the registered state only, so no input has a
// combinational path to an output.
// -----------------------------------------------------------------------------
module pwr_seq_ctrl #(
    parameter int CW        = 32,
    parameter int T_PWR     = 100000,
    parameter int T_RST     = 10000,
    parameter int T_LOCK    = 1000000,
    parameter int LOCK_FILT = 16,
    parameter int MAX_RETRY = 3,
    parameter int RW        = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pwrdwn_in,
    input  logic          reset_in,
    input  logic          lock,
    output logic          pwr_en,
    output logic          dev_rst_n,
    output logic          sys_rst,
    output logic          ready,
    output logic          fault,
    output logic [RW-1:0] retry_cnt
);

    localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT + 1) : 1;

    localparam logic [CW-1:0] PWR_LAST  = CW'(T_PWR - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(T_RST - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(T_LOCK - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWR_UP    = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RUN       = 3'd4,
        ST_RETRY     = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic [FW-1:0]   filt_reg;
    logic [RW-1:0]   retry_reg;
    logic            sync1_reg;
    logic            lock_s_reg;

    logic            lock_trusted;
    logic            filt_done;
    logic            pwrdwn_req;
    logic            state_change;

    // Lock from a device that is powered down or held in reset means nothing,
    // so the synchroniser is flushed in those states. A fresh lock must then
    // travel through both flops after dev_rst_n releases, which keeps the
    // minimum sequence at T_PWR+T_RST+2+LOCK_FILT even if lock was already high.
    assign lock_trusted = (state_reg == ST_WAIT_LOCK) || (state_reg == ST_RUN);

    // The filter counter holds the number of earlier consecutive lock_s cycles.
    // This cycle with lock_s=1 completes the LOCK_FILT-long run.
    assign filt_done    = lock_s_reg && (filt_reg == FILT_LAST);

    // Power-down wins everywhere except FAULT, which only reset_n can leave.
    assign pwrdwn_req   = pwrdwn_in && (state_reg != ST_FAULT);
    assign state_change = (state_next != state_reg);

    // ---------------------------------------------------------------- sync
    always_ff @(posedge clk) begin
        if (!reset_n || !lock_trusted) begin
            sync1_reg  <= 1'b0;
            lock_s_reg <= 1'b0;
        end else begin
            sync1_reg  <= lock;
            lock_s_reg <= sync1_reg;
        end
    end

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_OFF;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        if (pwrdwn_req) begin
            state_next = ST_OFF;
        end else if (reset_in && lock_trusted) begin
            state_next = ST_RST_HOLD;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    state_next = ST_PWR_UP;
                end
                ST_PWR_UP: begin
                    if (cnt_reg == PWR_LAST) begin
                        state_next = ST_RST_HOLD;
                    end
                end
                ST_RST_HOLD: begin
                    // The counter saturates, so an indefinitely long reset_in
                    // still satisfies the minimum hold once it drops.
                    if ((cnt_reg >= RST_LAST) && !reset_in) begin
                        state_next = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock completing on the timeout cycle still counts as success.
                    if (filt_done) begin
                        state_next = ST_RUN;
                    end else if (cnt_reg == LOCK_LAST) begin
                        state_next = (retry_reg < RETRY_MAX) ? ST_RETRY : ST_FAULT;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_reg) begin
                        state_next = ST_WAIT_LOCK;
                    end
                end
                ST_RETRY: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = ST_PWR_UP;
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_OFF;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        pwr_en    = 1'b0;
        dev_rst_n = 1'b0;
        sys_rst   = 1'b1;
        ready     = 1'b0;
        fault     = 1'b0;
        case (state_reg)
            ST_PWR_UP, ST_RST_HOLD: begin
                pwr_en = 1'b1;
            end
            ST_WAIT_LOCK: begin
                pwr_en    = 1'b1;
                dev_rst_n = 1'b1;
            end
            ST_RUN: begin
                pwr_en    = 1'b1;
                dev_rst_n = 1'b1;
                sys_rst   = 1'b0;
                ready     = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                pwr_en = 1'b0;
            end
        endcase
    end

    assign retry_cnt = retry_reg;

    // ---------------------------------------------------------------- dwell counter
    always_ff @(posedge clk) begin
        if (!reset_n || state_change) begin
            cnt_reg <= '0;
        end else if (cnt_reg != {CW{1'b1}}) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // ---------------------------------------------------------------- lock filter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_reg <= '0;
        end else if ((state_reg == ST_WAIT_LOCK) && !state_change && lock_s_reg) begin
            filt_reg <= filt_reg + 1'b1;
        end else begin
            filt_reg <= '0;
        end
    end

    // ---------------------------------------------------------------- retry counter
    // RETRY is entered only while retry_reg < MAX_RETRY, so the counter cannot
    // exceed MAX_RETRY or wrap.
    always_ff @(posedge clk) begin
        if (!reset_n || pwrdwn_req) begin
            retry_reg <= '0;
        end else if ((state_next == ST_RETRY) && (state_reg != ST_RETRY)) begin
            retry_reg <= retry_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwr_seq_ctrl
//
// Bench for pwr_seq_ctrl with short timing parameters. It runs in three parts:
//   1. A vector table that covers the nominal power-up sequence and a one-cycle
//      lock drop in RUN. Every cycle of each row is compared against the row's
//      expected outputs.
//   2. Hand-written sequences that cover reset_in holds, retries to FAULT,
//      power-down after a retry, reset_n in RUN and FAULT, and a short lock
//      glitch.
//   3. Random stimulus compared each cycle against a behavioural model. The
//      model tracks the current phase, the time spent in it, and how long lock
//      has been trusted.
// -----------------------------------------------------------------------------
module tb_pwr_seq_ctrl;

    localparam int CW        = 16;
    localparam int T_PWR     = 8;
    localparam int T_RST     = 4;
    localparam int T_LOCK    = 20;
    localparam int LOCK_FILT = 4;
    localparam int MAX_RETRY = 2;
    localparam int RW        = 4;

    // {pwr_en, dev_rst_n, sys_rst, ready, fault}
    localparam logic [4:0] O_OFF   = 5'b00100;
    localparam logic [4:0] O_PWR   = 5'b10100;
    localparam logic [4:0] O_WL    = 5'b11100;
    localparam logic [4:0] O_RUN   = 5'b11010;
    localparam logic [4:0] O_RETRY = 5'b00100;
    localparam logic [4:0] O_FAULT = 5'b00101;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pwrdwn_in;
    logic          reset_in;
    logic          lock;
    logic          pwr_en;
    logic          dev_rst_n;
    logic          sys_rst;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retry_cnt;
    logic [4:0]    outs;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign outs = {pwr_en, dev_rst_n, sys_rst, ready, fault};

    pwr_seq_ctrl #(
        .CW        (CW),
        .T_PWR     (T_PWR),
        .T_RST     (T_RST),
        .T_LOCK    (T_LOCK),
        .LOCK_FILT (LOCK_FILT),
        .MAX_RETRY (MAX_RETRY),
        .RW        (RW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pwrdwn_in (pwrdwn_in),
        .reset_in  (reset_in),
        .lock      (lock),
        .pwr_en    (pwr_en),
        .dev_rst_n (dev_rst_n),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    // ------------------------------------------------------------ reference model
    typedef enum {M_OFF, M_PWR, M_RSTH, M_WL, M_RUN, M_RETRY, M_FAULT} mph_t;

    mph_t m_ph      = M_OFF;
    int   m_age     = 0;    // cycles already spent in the current phase
    int   m_retries = 0;
    int   m_goodrun = 0;    // consecutive trusted-lock cycles seen in this WL visit
    bit   m_pipe1   = 1'b0; // lock sampled one edge ago, if the device was live
    bit   m_lock_s  = 1'b0; // trusted lock during the current cycle

    function automatic logic [4:0] model_outs(input mph_t ph);
        case (ph)
            M_PWR, M_RSTH: return O_PWR;
            M_WL:          return O_WL;
            M_RUN:         return O_RUN;
            M_RETRY:       return O_RETRY;
            M_FAULT:       return O_FAULT;
            default:       return O_OFF;
        endcase
    endfunction

    task automatic model_step(input logic rn, input logic pd, input logic ri, input logic lk);
        mph_t nph;
        bit   live;
        bit   ls;
        ls   = m_lock_s;
        live = (m_ph == M_WL) || (m_ph == M_RUN);
        if (!rn) begin
            m_ph      = M_OFF;
            m_age     = 0;
            m_retries = 0;
            m_goodrun = 0;
            m_pipe1   = 1'b0;
            m_lock_s  = 1'b0;
        end else begin
            nph = m_ph;
            if (pd && m_ph != M_FAULT) nph = M_OFF;
            else if (ri && live) nph = M_RSTH;
            else begin
                case (m_ph)
                    M_OFF:   nph = M_PWR;
                    M_PWR:   if (m_age + 1 == T_PWR) nph = M_RSTH;
                    M_RSTH:  if (m_age + 1 >= T_RST && !ri) nph = M_WL;
                    M_WL: begin
                        if (ls && m_goodrun + 1 == LOCK_FILT) nph = M_RUN;
                        else if (m_age + 1 == T_LOCK)
                            nph = (m_retries < MAX_RETRY) ? M_RETRY : M_FAULT;
                    end
                    M_RUN:   if (!ls) nph = M_WL;
                    M_RETRY: if (m_age + 1 == T_RST) nph = M_PWR;
                    default: nph = m_ph;
                endcase
            end
            m_goodrun = (m_ph == M_WL && nph == M_WL && ls) ? m_goodrun + 1 : 0;
            if (pd && m_ph != M_FAULT) m_retries = 0;
            else if (nph == M_RETRY && m_ph != M_RETRY) m_retries = m_retries + 1;
            m_age    = (nph == m_ph) ? m_age + 1 : 0;
            m_lock_s = live ? m_pipe1 : 1'b0;
            m_pipe1  = live ? lk : 1'b0;
            m_ph     = nph;
        end
    endtask

    // ------------------------------------------------------------ drivers / checks
    // Drive the inputs, clock them in, and compare 1 ns after the edge.
    task automatic run(input logic rn, input logic pd, input logic ri, input logic lk,
                       input int n, input logic [4:0] exp, input int exp_rc,
                       input string name);
        for (int i = 0; i < n; i++) begin
            reset_n   = rn;
            pwrdwn_in = pd;
            reset_in  = ri;
            lock      = lk;
            @(posedge clk);
            model_step(rn, pd, ri, lk);
            #1;
            n_checks++;
            if (outs !== exp || retry_cnt !== RW'(exp_rc)) begin
                n_errors++;
                $display("FAIL %s cycle %0d: outs(pwr_en,dev_rst_n,sys_rst,ready,fault)=%b retry_cnt=%0d, required %b retry_cnt=%0d",
                         name, cyc, outs, retry_cnt, exp, exp_rc);
            end
        end
        $display("[cyc %0d] %s: %0d cycle(s) rn=%b pd=%b ri=%b lock=%b",
                 cyc, name, n, rn, pd, ri, lk);
    endtask

    typedef struct {
        logic       rn;
        logic       pd;
        logic       ri;
        logic       lk;
        int         n;
        logic [4:0] exp;
        int         rc;
        string      name;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        pwrdwn_in = 1'b1;
        reset_in  = 1'b0;
        lock      = 1'b1;

        // Nominal sequence: pwrdwn_in falls after edge 10, so pwr_en rises at
        // edge 11, dev_rst_n at edge 23, and ready at edge 29. A one-cycle lock
        // drop then returns the sequencer to WAIT_LOCK for 4 cycles.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1,  2, O_OFF, 0, "reset"};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1,  8, O_OFF, 0, "off_hold"};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 12, O_PWR, 0, "pwr_up_rst_hold"};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1,  6, O_WL,  0, "wait_lock"};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1,  3, O_RUN, 0, "run"};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, O_RUN, 0, "lock_drop"};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1,  1, O_RUN, 0, "lock_back_sync"};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1,  4, O_WL,  0, "relock_wait"};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1,  3, O_RUN, 0, "relocked"};

        for (int v = 0; v < 9; v++) begin
            run(vecs[v].rn, vecs[v].pd, vecs[v].ri, vecs[v].lk,
                vecs[v].n, vecs[v].exp, vecs[v].rc, vecs[v].name);
        end

        // reset_in in RUN drops to RST_HOLD, then holds for 50 cycles in total.
        run(1, 0, 1, 1,  1, O_PWR, 0, "rst_in_run");
        run(1, 0, 1, 1, 49, O_PWR, 0, "rst_in_hold");
        run(1, 0, 0, 1,  1, O_WL,  0, "rst_in_release");
        run(1, 0, 0, 1,  5, O_WL,  0, "rst_in_relock");
        run(1, 0, 0, 1,  2, O_RUN, 0, "rst_in_run_again");

        // reset_n asserted while in RUN.
        run(0, 0, 0, 1,  1, O_OFF, 0, "reset_n_in_run");

        // Lock never rises: two retries, then FAULT.
        run(1, 0, 0, 0, 12, O_PWR,   0, "nolock_pwr1");
        run(1, 0, 0, 0, 20, O_WL,    0, "nolock_wl1");
        run(1, 0, 0, 0,  4, O_RETRY, 1, "retry1");
        run(1, 0, 0, 0, 12, O_PWR,   1, "nolock_pwr2");
        run(1, 0, 0, 0, 20, O_WL,    1, "nolock_wl2");
        run(1, 0, 0, 0,  4, O_RETRY, 2, "retry2");
        run(1, 0, 0, 0, 12, O_PWR,   2, "nolock_pwr3");
        run(1, 0, 0, 0, 20, O_WL,    2, "nolock_wl3");
        run(1, 0, 0, 0,  3, O_FAULT, 2, "fault");
        run(1, 1, 0, 0,  3, O_FAULT, 2, "fault_pwrdwn_ignored");
        run(1, 0, 1, 1,  3, O_FAULT, 2, "fault_rst_in_ignored");
        run(1, 0, 0, 1, 10, O_FAULT, 2, "fault_lock_ignored");
        run(0, 1, 0, 0,  1, O_OFF,   0, "reset_n_in_fault");

        // pwrdwn_in in WAIT_LOCK after one retry clears retry_cnt.
        run(1, 0, 0, 0, 12, O_PWR,   0, "pd_pwr1");
        run(1, 0, 0, 0, 20, O_WL,    0, "pd_wl1");
        run(1, 0, 0, 0,  4, O_RETRY, 1, "pd_retry");
        run(1, 0, 0, 0, 12, O_PWR,   1, "pd_pwr2");
        run(1, 0, 0, 0,  5, O_WL,    1, "pd_wl2");
        run(1, 1, 0, 0,  1, O_OFF,   0, "pd_to_off");

        // A lock pulse shorter than LOCK_FILT must not reach RUN.
        run(1, 0, 0, 0, 12, O_PWR,   0, "glitch_pwr");
        run(1, 0, 0, 0,  2, O_WL,    0, "glitch_pre");
        run(1, 0, 0, 1,  3, O_WL,    0, "glitch_pulse");
        run(1, 0, 0, 0, 15, O_WL,    0, "glitch_post");
        run(1, 0, 0, 0,  1, O_RETRY, 1, "glitch_timeout");

        // Random stimulus compared against the model.
        begin
            logic rn;
            logic pd;
            logic ri;
            logic lk;
            int   rand_errs;
            rand_errs = 0;
            run(0, 1, 0, 0, 2, O_OFF, 0, "random_reset");
            lk = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                rn = ($urandom_range(0, 399) != 0);
                pd = ($urandom_range(0, 99) < 2);
                ri = ($urandom_range(0, 99) < 3);
                if ($urandom_range(0, 6) == 0) lk = ~lk;
                reset_n   = rn;
                pwrdwn_in = pd;
                reset_in  = ri;
                lock      = lk;
                @(posedge clk);
                model_step(rn, pd, ri, lk);
                #1;
                n_checks++;
                if (outs !== model_outs(m_ph) || retry_cnt !== RW'(m_retries)) begin
                    n_errors++;
                    rand_errs++;
                    $display("FAIL random cycle %0d: outs=%b retry_cnt=%0d, required %b retry_cnt=%0d",
                             cyc, outs, retry_cnt, model_outs(m_ph), m_retries);
                end
            end
            $display("[cyc %0d] random: 4000 cycles, %0d differing", cyc, rand_errs);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
